// File: rtl/serial_tx.sv
// Parallel-to-serial transmitter: frames each W-bit word as start(0), data LSB first, stop(1)
// and paces the producer with a four-phase dav_/rfd handshake.
module serial_tx #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset_,
    input  logic         dav_,
    input  logic [W-1:0] byte_in,
    output logic         rfd,
    output logic         out,
    output logic [2:0]   dbg_state
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        DATA     = 3'd2,
        STOP     = 3'd3,
        WAIT_END = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  sr_q, sr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rfd_q, rfd_d;
    logic          out_q, out_d;

    // Handshake: the producer holds byte_in and drives dav_=0 while rfd=1; the word is taken
    // on the first such edge and rfd drops. rfd only returns to 1 once the frame has ended
    // AND dav_ has gone back to 1, so a word held on dav_=0 is never sent twice.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        rfd_d   = rfd_q;
        out_d   = out_q;
        case (state_q)
            IDLE: begin
                rfd_d = 1'b1;
                out_d = 1'b1;
                if (!dav_) begin
                    sr_d    = byte_in;
                    cnt_d   = '0;
                    rfd_d   = 1'b0;
                    out_d   = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                out_d   = sr_q[0];
                sr_d    = {1'b0, sr_q[W-1:1]};
                state_d = DATA;
            end
            DATA: begin
                // CNT saturates at W-1 so it never wraps inside a frame.
                if (cnt_q == CNT_LAST) begin
                    out_d   = 1'b1;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    out_d = sr_q[0];
                    sr_d  = {1'b0, sr_q[W-1:1]};
                end
            end
            STOP: begin
                out_d   = 1'b1;
                rfd_d   = 1'b0;
                state_d = WAIT_END;
            end
            WAIT_END: begin
                out_d = 1'b1;
                rfd_d = 1'b0;
                if (dav_) begin
                    rfd_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                out_d   = 1'b1;
                rfd_d   = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            rfd_q   <= 1'b1;
            out_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            rfd_q   <= rfd_d;
            out_q   <= out_d;
        end
    end

    assign rfd       = rfd_q;
    assign out       = out_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: queue-based frame model checked every cycle, plus directed frames
// compared against hand-written bit patterns, then a randomized phase.
module tb_serial_tx;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset_;
    logic         dav_;
    logic [W-1:0] byte_in;
    logic         rfd;
    logic         out;
    logic [2:0]   dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    logic out_seq [0:39];
    logic rfd_seq [0:39];

    always #5 clock = ~clock;

    serial_tx #(.W(W)) dut (
        .clock     (clock),
        .reset_    (reset_),
        .dav_      (dav_),
        .byte_in   (byte_in),
        .rfd       (rfd),
        .out       (out),
        .dbg_state (dbg_state)
    );

    // Reference model: an accepted word becomes a queue of line levels, one per cycle:
    // start 0, W data bits LSB first, stop 1, one more idle 1 before dav_ is looked at again.
    logic exp_q[$];
    logic m_cur  = 1'b1;
    bit   m_busy = 1'b0;

    always @(posedge clock) begin
        if (!reset_) begin
            exp_q.delete();
            m_busy = 1'b0;
            m_cur  = 1'b1;
        end else if (!m_busy) begin
            m_cur = 1'b1;
            if (!dav_) begin
                exp_q.push_back(1'b0);
                for (int i = 0; i < W; i++) exp_q.push_back(byte_in[i]);
                exp_q.push_back(1'b1);
                exp_q.push_back(1'b1);
                m_busy = 1'b1;
                m_cur  = exp_q.pop_front();
            end
        end else if (exp_q.size() > 0) begin
            m_cur = exp_q.pop_front();
        end else begin
            m_cur = 1'b1;
            if (dav_) m_busy = 1'b0;
        end
    end

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    task automatic check_frame(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            check_bit("model_out", out, m_cur);
            check_bit("model_rfd", rfd, !m_busy);
        end
    end

    // Called at a negedge with the DUT idle; records out/rfd at the negedge after edges E..E+n-1.
    task automatic send(input logic [W-1:0] w, input int hold, input int n,
                        input int chg_k, input logic [W-1:0] chg_val);
        byte_in = w;
        dav_    = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            out_seq[k] = out;
            rfd_seq[k] = rfd;
            if (k + 1 == hold) dav_ = 1'b1;
            if (k == chg_k) byte_in = chg_val;
        end
    endtask

    function automatic logic [9:0] packed_frame();
        logic [9:0] p;
        for (int k = 0; k < 10; k++) p[k] = out_seq[k];
        return p;
    endfunction

    initial begin
        logic ok;
        reset_  = 1'b0;
        dav_    = 1'b1;
        byte_in = '0;
        repeat (3) @(negedge clock);
        chk_en = 1'b1;
        check_bit("reset_out", out, 1'b1);
        check_bit("reset_rfd", rfd, 1'b1);
        reset_ = 1'b1;
        @(negedge clock);

        // basic frame
        send(8'hA5, 1, 12, -1, 8'h00);
        check_frame("a5_frame", packed_frame(), 10'b1101001010);
        check_bit("a5_rfd_e10", rfd_seq[10], 1'b0);
        check_bit("a5_rfd_e11", rfd_seq[11], 1'b1);
        repeat (2) @(negedge clock);

        // dav_ held low for 20 cycles: one frame only
        send(8'h3C, 20, 24, -1, 8'h00);
        check_frame("3c_frame", packed_frame(), 10'b1001111000);
        check_bit("3c_rfd_e19", rfd_seq[19], 1'b0);
        check_bit("3c_rfd_e20", rfd_seq[20], 1'b1);
        ok = 1'b1;
        for (int k = 10; k < 24; k++) if (out_seq[k] !== 1'b1) ok = 1'b0;
        check_bit("3c_no_second_frame", ok, 1'b1);
        repeat (2) @(negedge clock);

        // byte_in changes at E+3
        send(8'hFF, 1, 12, 2, 8'h00);
        check_frame("ff_frame_input_change", packed_frame(), 10'b1111111110);
        repeat (2) @(negedge clock);

        // reset sampled at E+4 of an 8'h00 frame
        byte_in = 8'h00;
        dav_    = 1'b0;
        @(negedge clock);
        dav_ = 1'b1;
        repeat (3) @(negedge clock);
        reset_ = 1'b0;
        @(negedge clock);
        check_bit("midreset_out", out, 1'b1);
        check_bit("midreset_rfd", rfd, 1'b1);
        reset_ = 1'b1;
        send(8'h5A, 1, 12, -1, 8'h00);
        check_frame("after_reset_frame", packed_frame(), 10'b1010110100);
        repeat (2) @(negedge clock);

        // back-to-back with a single dav_=1 cycle between words
        send(8'h01, 11, 12, -1, 8'h00);
        check_frame("b2b_first", packed_frame(), 10'b1000000010);
        check_bit("b2b_rfd_e11", rfd_seq[11], 1'b1);
        send(8'h80, 1, 12, -1, 8'h00);
        check_frame("b2b_second", packed_frame(), 10'b1100000000);
        repeat (2) @(negedge clock);

        // reset and dav_ on the same edge
        reset_  = 1'b0;
        dav_    = 1'b0;
        byte_in = 8'hA5;
        @(negedge clock);
        check_bit("prio_out", out, 1'b1);
        check_bit("prio_rfd", rfd, 1'b1);
        reset_ = 1'b1;
        dav_   = 1'b1;
        ok = 1'b1;
        repeat (3) begin
            @(negedge clock);
            if (out !== 1'b1 || rfd !== 1'b1) ok = 1'b0;
        end
        check_bit("prio_no_frame", ok, 1'b1);

        // randomized traffic, checked by the model every cycle
        for (int c = 0; c < 600; c++) begin
            reset_  = ($urandom_range(0, 79) != 0);
            dav_    = ($urandom_range(0, 2) != 0);
            byte_in = W'($urandom);
            @(negedge clock);
        end
        reset_ = 1'b1;
        dav_   = 1'b1;
        repeat (15) @(negedge clock);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
